// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_pkg
//
// Shared definitions for the bit-serial adder controller: the controller state
// encoding and the default operand width. Imported by the controller and by
// anything that needs to interpret its state (e.g. a testbench).
// -----------------------------------------------------------------------------
package serial_add_ctrl_pkg;

  // Default operand width; legal widths are 2..32.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states. The encoding is fixed so that external observers can
  // decode the state register directly.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_add_ctrl_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// The shared single-bit full adder cell. Purely combinational.
//
// Ports:
//   Ain  - operand A bit
//   Bin  - operand B bit
//   Cin  - carry in
//   Sout - sum bit    (Ain ^ Bin ^ Cin)
//   Cout - carry out  (majority of Ain, Bin, Cin)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic Ain,
  input  logic Bin,
  input  logic Cin,
  output logic Sout,
  output logic Cout
);

  assign Sout = Ain ^ Bin ^ Cin;
  assign Cout = (Ain & Bin) | (Ain & Cin) | (Bin & Cin);

endmodule : full_adder

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder controller. Adds two WIDTH-bit operands plus a carry-in by
// stepping a single full_adder cell over WIDTH clock cycles, LSB first.
// {cout, sum} = a + b + cin, wrapping modulo 2^(WIDTH+1).
//
// Handshake: a start pulse in IDLE or DONE samples a/b/cin and enters RUN.
// busy is high for the WIDTH RUN cycles, then done pulses for one cycle while
// sum/cout present the new result. start is ignored during RUN. Holding start
// in the DONE cycle chains the next addition with no idle gap.
//
// Parameters:
//   WIDTH  - operand width, 2..32
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous, active-high reset (aborts any addition in flight)
//   start  - request; operands sampled on the accepting edge
//   a, b   - operands
//   cin    - carry into bit 0
//   busy   - high exactly while in RUN
//   done   - one-cycle pulse when a new result is presented
//   sum    - result, held until the next completion or reset
//   cout   - carry out of bit WIDTH-1, held with sum
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e             state;
  state_e             state_next;

  logic [WIDTH-1:0]   a_sh;     // operand A, shifted right one bit per RUN cycle
  logic [WIDTH-1:0]   b_sh;     // operand B, shifted right one bit per RUN cycle
  logic [WIDTH-1:0]   sum_sh;   // partial sum, filled from the MSB downwards
  logic               carry_q;  // carry between successive bit positions
  logic [CNT_W-1:0]   bit_cnt;  // index of the bit processed this RUN cycle
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  // Full adder interface
  logic               fa_sout;
  logic               fa_cout;

  // A request is taken only when the controller is not mid-addition.
  logic               accept;
  logic               last_bit;
  logic [WIDTH-1:0]   sum_sh_next;

  assign accept      = start && ((state == IDLE) || (state == DONE));
  assign last_bit    = (state == RUN) && (bit_cnt == LAST_BIT);
  // After the final shift the LSB of the operands has landed in bit 0.
  assign sum_sh_next = {fa_sout, sum_sh[WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // The one shared adder cell; the controller contains no other arithmetic
  // besides the bit counter.
  // ---------------------------------------------------------------------------
  full_adder u_full_adder (
    .Ain  (a_sh[0]),
    .Bin  (b_sh[0]),
    .Cin  (carry_q),
    .Sout (fa_sout),
    .Cout (fa_cout)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no
    // latch is inferred for state_next.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) state_next = RUN;
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        // Back-to-back request skips IDLE entirely.
        state_next = accept ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (pure decodes of the registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand/sum shift registers, carry, counter, result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry_q <= 1'b0;
      bit_cnt <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      a_sh    <= a;
      b_sh    <= b;
      carry_q <= cin;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_sh  <= sum_sh_next;
      carry_q <= fa_cout;
      bit_cnt <= bit_cnt + CNT_W'(1);
      // Result registers move only on the RUN->DONE edge, so sum/cout stay
      // stable for the whole of the next addition.
      if (last_bit) begin
        sum_q  <= sum_sh_next;
        cout_q <= fa_cout;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_add_ctrl

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller. Sequences the team's single-bit `full_adder` over WIDTH clock cycles to add two WIDTH-bit operands plus a carry-in, LSB first. Provides a start/busy/done handshake towards the requester. Sits between a requester that supplies operands and the shared one-bit adder cell, trading area for latency.

## Interface
- WIDTH, 8 — operand width in bits; legal range 2..32

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; operands sampled on the accepting edge
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for bit 0
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result, held until the next completion
- cout  output  1  carry out of bit WIDTH-1, held with sum

## Operation
- Reset is synchronous and active-high. One clock, clk; all state updates on its rising edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch a, b into shift registers a_sh, b_sh; carry register ← cin; bit counter ← 0; go to RUN.
  - start=0 → stay in IDLE.
- RUN, each cycle:
  - Present a_sh[0], b_sh[0] and the carry register to the full_adder.
  - Shift Sout into the MSB of a sum shift register; shift a_sh and b_sh right by one.
  - Carry register ← Cout; counter increments.
  - When the counter reaches WIDTH-1 on this edge (last bit), go to DONE.
- Result capture: on the RUN→DONE edge, copy the completed sum shift register and the final carry to the sum and cout output registers.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 → accepted exactly as in IDLE; go straight to RUN (back-to-back operation).
  - start=0 → go to IDLE.
- start is ignored while in RUN. No queuing, and a/b changes during RUN have no effect.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). Results wrap with no overflow flag.
- Counter width is $clog2(WIDTH).

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. All shift registers, the carry register and the counter are 0.
- Reset mid-RUN aborts the operation on that edge. sum and cout are cleared to 0, and no done pulse is produced.
- busy is a registered state decode: 1 exactly in RUN.
- Cycle numbering for a start accepted at edge 0:
  - Edges 1..WIDTH each process one bit (bits 0..WIDTH-1).
  - busy is high for WIDTH cycles following edge 0.
  - done and the new sum/cout become visible after edge WIDTH.
- Latency from the start-sampling edge to done high is WIDTH cycles. Throughput is one addition per WIDTH+1 cycles, including back-to-back operation from DONE.
- sum and cout change only at the RUN→DONE edge or at reset. They are stable in IDLE, RUN and DONE otherwise.
- rst and start asserted together: rst wins and the state stays IDLE.

## Structure
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant. The bench reuses these constants.
- Sub-module: exactly one instance of the existing `full_adder` (ports Ain, Bin, Cin, Sout, Cout). The controller adds no other arithmetic.
- The controller itself is one module containing the FSM, counter, operand and sum shift registers, the carry register and the output registers.

## Test plan
- WIDTH=8, a=8'h3C, b=8'h5A, cin=0, start pulsed once → busy high for 8 cycles, done after 8 cycles, sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- start re-pulsed at cycle 3 of RUN with different a/b → ignored. The result matches the original operands, and there is exactly one done pulse.
- rst asserted at cycle 4 of RUN → next cycle state IDLE, busy=0, sum=0, cout=0, no done. A subsequent start of 8'h01+8'h01 gives sum=8'h02.
- start held high during the DONE cycle with new operands 8'h10+8'h20 → re-enters RUN immediately. The second done arrives 9 cycles after the first with sum=8'h30.
- WIDTH=4 exhaustive: all 512 combinations of a, b, cin → {cout,sum} equals a+b+cin for every case, with the error count reported at the end and required to be 0.
